// File: rtl/branch_predict_unit_pkg.sv
// Shared constants for the branch predict unit: jump opcodes, pipe
// register flush bits and the full mispredict flush mask.
package branch_predict_unit_pkg;

    localparam int JUMP_BITS = 4;

    localparam logic [JUMP_BITS-1:0] JMP_OP_NOP = 4'd0;
    localparam logic [JUMP_BITS-1:0] JMP_OP_J   = 4'd1;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JR  = 4'd2;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JEQ = 4'd3;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JZ  = 4'd4;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JNE = 4'd5;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JNZ = 4'd6;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JL  = 4'd7;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JLE = 4'd8;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JG  = 4'd9;
    localparam logic [JUMP_BITS-1:0] JMP_OP_JGE = 4'd10;

    localparam int NUM_PIPE_MASKS = 5;

    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_PC     = 5'b00001;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_IF_ID  = 5'b00010;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_ID_EX  = 5'b00100;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_EX_MEM = 5'b01000;
    localparam logic [NUM_PIPE_MASKS-1:0] PIPE_REG_MEM_WB = 5'b10000;

    // Everything upstream of MEM is squashed on a mispredict.
    localparam logic [NUM_PIPE_MASKS-1:0] FLUSH_MISPREDICT =
        PIPE_REG_EX_MEM | PIPE_REG_ID_EX | PIPE_REG_IF_ID | PIPE_REG_PC;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Pipeline <-> branch predict unit bus.
//   IF side : pc -> take_branch, branch_predict
//   EX side : ex_valid, jop, flags, id_ex_* addresses, carried prediction
//             -> flush, jump_address
//   Perf    : mispredict_count, branch_count
// master = pipeline, slave = branch_predict_unit.
interface branch_predict_unit_if
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int PERF_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]     pc;
    logic                      take_branch;
    logic [ADDR_WIDTH-1:0]     branch_predict;
    logic                      ex_valid;
    logic [JUMP_BITS-1:0]      jop;
    logic                      zero;
    logic                      less;
    logic                      greater;
    logic [ADDR_WIDTH-1:0]     id_ex_pc;
    logic [ADDR_WIDTH-1:0]     id_ex_reg_address;
    logic [ADDR_WIDTH-1:0]     id_ex_imm_address;
    logic                      branch_taken;
    logic [ADDR_WIDTH-1:0]     branch_taken_address;
    logic [NUM_PIPE_MASKS-1:0] flush;
    logic [ADDR_WIDTH-1:0]     jump_address;
    logic [PERF_WIDTH-1:0]     mispredict_count;
    logic [PERF_WIDTH-1:0]     branch_count;

    modport master (
        output pc, ex_valid, jop, zero, less, greater, id_ex_pc,
               id_ex_reg_address, id_ex_imm_address, branch_taken,
               branch_taken_address,
        input  take_branch, branch_predict, flush, jump_address,
               mispredict_count, branch_count
    );

    modport slave (
        input  pc, ex_valid, jop, zero, less, greater, id_ex_pc,
               id_ex_reg_address, id_ex_imm_address, branch_taken,
               branch_taken_address,
        output take_branch, branch_predict, flush, jump_address,
               mispredict_count, branch_count
    );
endinterface

// File: rtl/branch_predict_unit_btb_table.sv
// Direct-mapped tagged branch target buffer.
//   clk, reset     : clock, async active-low reset (clears every entry)
//   rd_pc          : fetch PC, combinational lookup
//   rd_taken       : valid & tag match & (uncond | ctr MSB)
//   rd_target      : entry target on tag match, else 0
//   wr_en          : a control-flow op resolved this cycle
//   wr_pc/taken/target/uncond : resolved op, applied at the clock edge
// Reads see the array before the edge; a same-index write this cycle is
// not forwarded.
module btb_table #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] rd_pc,
    output logic                  rd_taken,
    output logic [ADDR_WIDTH-1:0] rd_target,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_pc,
    input  logic                  wr_taken,
    input  logic [ADDR_WIDTH-1:0] wr_target,
    input  logic                  wr_uncond
);
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - IDX;

    localparam logic [CTR_BITS-1:0] CTR_MAX        = '1;
    localparam logic [CTR_BITS-1:0] CTR_MIN        = '0;
    localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef struct packed {
        logic                  valid;
        logic                  uncond;
        logic [TAG_W-1:0]      tag;
        logic [ADDR_WIDTH-1:0] target;
        logic [CTR_BITS-1:0]   ctr;
    } entry_t;

    entry_t mem_q [BTB_ENTRIES];

    logic [IDX-1:0]   rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_match;
    entry_t           cur, nxt;
    logic             wr_hit, wr_we;

    assign rd_idx = rd_pc[IDX-1:0];
    assign rd_tag = rd_pc[ADDR_WIDTH-1:IDX];
    assign wr_idx = wr_pc[IDX-1:0];
    assign wr_tag = wr_pc[ADDR_WIDTH-1:IDX];

    // Target is returned on tag match alone; entries are zeroed on reset so
    // an unpopulated slot yields 0 regardless.
    assign rd_match  = (mem_q[rd_idx].tag == rd_tag);
    assign rd_taken  = mem_q[rd_idx].valid & rd_match &
                       (mem_q[rd_idx].uncond | mem_q[rd_idx].ctr[CTR_BITS-1]);
    assign rd_target = rd_match ? mem_q[rd_idx].target : '0;

    always_comb begin
        cur    = mem_q[wr_idx];
        nxt    = cur;
        wr_hit = cur.valid & (cur.tag == wr_tag);
        wr_we  = 1'b0;
        if (wr_hit) begin
            wr_we = wr_en;
            if (wr_taken) begin
                nxt.target = wr_target;
                if (cur.ctr != CTR_MAX) nxt.ctr = cur.ctr + CTR_BITS'(1);
            end else if (cur.ctr != CTR_MIN) begin
                nxt.ctr = cur.ctr - CTR_BITS'(1);
            end
        end else if (wr_taken) begin
            // Miss on a taken op: evict whatever lives at this index.
            wr_we = wr_en;
            nxt   = '{valid: 1'b1, uncond: wr_uncond, tag: wr_tag,
                      target: wr_target, ctr: CTR_WEAK_TAKEN};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_ENTRIES; i++) mem_q[i] <= '0;
        end else if (wr_we) begin
            mem_q[wr_idx] <= nxt;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: BTB lookup for IF, branch resolution in EX, BTB
// update, flush mask / redirect generation and mispredict perf counters.
//   clk, reset : clock, async active-low reset
//   bus        : branch_predict_unit_if.slave (see interface header)
// Build option: define BRU_PERF_CNT_EN to keep the perf counters; without it
// mispredict_count and branch_count are tied to 0.
// BTB_ENTRIES must be a power of 2 and at least 2.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int BTB_ENTRIES = 16,
    parameter int CTR_BITS    = 2,
    parameter int PERF_WIDTH  = 32
) (
    input logic                  clk,
    input logic                  reset,
    branch_predict_unit_if.slave bus
);
    logic                  resolve, taken, uncond, mispredict;
    logic [ADDR_WIDTH-1:0] target;
    logic                  lk_taken;
    logic [ADDR_WIDTH-1:0] lk_target;

    btb_table #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BTB_ENTRIES(BTB_ENTRIES),
        .CTR_BITS   (CTR_BITS)
    ) u_btb (
        .clk      (clk),
        .reset    (reset),
        .rd_pc    (bus.pc),
        .rd_taken (lk_taken),
        .rd_target(lk_target),
        .wr_en    (resolve),
        .wr_pc    (bus.id_ex_pc),
        .wr_taken (taken),
        .wr_target(target),
        .wr_uncond(uncond)
    );

    assign bus.take_branch    = lk_taken;
    assign bus.branch_predict = lk_target;

    assign resolve = bus.ex_valid && (bus.jop != JMP_OP_NOP);
    assign uncond  = (bus.jop == JMP_OP_J) || (bus.jop == JMP_OP_JR);
    assign target  = (bus.jop == JMP_OP_JR) ? bus.id_ex_reg_address
                                            : bus.id_ex_imm_address;

    always_comb begin
        taken = 1'b0;
        if (resolve) begin
            case (bus.jop)
                JMP_OP_J, JMP_OP_JR:    taken = 1'b1;
                JMP_OP_JEQ, JMP_OP_JZ:  taken = bus.zero;
                JMP_OP_JNE, JMP_OP_JNZ: taken = !bus.zero;
                JMP_OP_JL:              taken = bus.less;
                JMP_OP_JLE:             taken = bus.less | bus.zero;
                JMP_OP_JG:              taken = bus.greater;
                JMP_OP_JGE:             taken = bus.greater | bus.zero;
                default:                taken = 1'b0;
            endcase
        end
    end

    // Wrong direction, or right direction with a stale target (JR).
    assign mispredict = resolve &&
        ((taken != bus.branch_taken) ||
         (taken && bus.branch_taken && (bus.branch_taken_address != target)));

    always_comb begin
        bus.flush = '0;
        if (mispredict)   bus.flush = FLUSH_MISPREDICT;
        else if (taken)   bus.flush = PIPE_REG_EX_MEM;
    end

    assign bus.jump_address = taken ? target : bus.id_ex_pc + ADDR_WIDTH'(1);

`ifdef BRU_PERF_CNT_EN
    logic [PERF_WIDTH-1:0] br_cnt_q, mis_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (resolve)    br_cnt_q  <= br_cnt_q + PERF_WIDTH'(1);
            if (mispredict) mis_cnt_q <= mis_cnt_q + PERF_WIDTH'(1);
        end
    end

    assign bus.branch_count     = br_cnt_q;
    assign bus.mispredict_count = mis_cnt_q;
`else
    assign bus.branch_count     = '0;
    assign bus.mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed steps plus random traffic against
// a table-of-entries reference model.
module tb_branch_predict_unit;
    import branch_predict_unit_pkg::*;

    localparam int AW = 16;
    localparam int N  = 16;
    localparam int CB = 2;
    localparam int PW = 32;
    localparam int CMAX = (1 << CB) - 1;
    localparam int CWEAK = 1 << (CB - 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.ADDR_WIDTH(AW), .PERF_WIDTH(PW)) bus ();

    branch_predict_unit #(
        .ADDR_WIDTH(AW), .BTB_ENTRIES(N), .CTR_BITS(CB), .PERF_WIDTH(PW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Reference model: one record per BTB slot, plain integers.
    bit          m_valid [N];
    int unsigned m_tag   [N];
    int unsigned m_tgt   [N];
    int          m_ctr   [N];
    bit          m_unc   [N];
    int unsigned m_bc, m_mc;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0; m_unc[i] = 0;
        end
        m_bc = 0; m_mc = 0;
    endfunction

    function automatic bit m_pred_tk(input int unsigned a);
        int unsigned i = a % N;
        return m_valid[i] && m_tag[i] == a / N && (m_unc[i] || m_ctr[i] >= CWEAK);
    endfunction

    function automatic int unsigned m_pred_tgt(input int unsigned a);
        int unsigned i = a % N;
        return (m_tag[i] == a / N) ? m_tgt[i] : 0;
    endfunction

    function automatic bit op_taken(input logic [3:0] op, input bit z, input bit l, input bit g);
        case (op)
            JMP_OP_J, JMP_OP_JR:    return 1;
            JMP_OP_JEQ, JMP_OP_JZ:  return z;
            JMP_OP_JNE, JMP_OP_JNZ: return !z;
            JMP_OP_JL:              return l;
            JMP_OP_JLE:             return l || z;
            JMP_OP_JG:              return g;
            JMP_OP_JGE:             return g || z;
            default:                return 0;
        endcase
    endfunction

    function automatic int unsigned exp_bc();
`ifdef BRU_PERF_CNT_EN
        return m_bc;
`else
        return 0;
`endif
    endfunction

    function automatic int unsigned exp_mc();
`ifdef BRU_PERF_CNT_EN
        return m_mc;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input logic [15:0] pc, input bit ev, input logic [3:0] op,
                         input bit z, input bit l, input bit g, input logic [15:0] ipc,
                         input logic [15:0] ra, input logic [15:0] ia,
                         input bit bt, input logic [15:0] bta);
        bus.pc = pc; bus.ex_valid = ev; bus.jop = op;
        bus.zero = z; bus.less = l; bus.greater = g;
        bus.id_ex_pc = ipc; bus.id_ex_reg_address = ra; bus.id_ex_imm_address = ia;
        bus.branch_taken = bt; bus.branch_taken_address = bta;
    endtask

    task automatic idle(input logic [15:0] pc);
        drive(pc, 0, JMP_OP_NOP, 0, 0, 0, 16'h0100, 0, 0, 0, 0);
    endtask

    // Called at a negedge with inputs applied: check everything against the
    // model, cross the rising edge, advance the model, return at the negedge.
    task automatic step();
        int unsigned tgt, ja, ei, et;
        bit res, tk, mis;
        logic [4:0] ef;
        #1;
        check("take_branch", bus.take_branch, m_pred_tk(bus.pc));
        check("branch_predict", bus.branch_predict, m_pred_tgt(bus.pc));
        res = bus.ex_valid && bus.jop != JMP_OP_NOP;
        tk  = res && op_taken(bus.jop, bus.zero, bus.less, bus.greater);
        tgt = (bus.jop == JMP_OP_JR) ? bus.id_ex_reg_address : bus.id_ex_imm_address;
        mis = res && (tk != bus.branch_taken ||
                      (tk && bus.branch_taken && bus.branch_taken_address != tgt));
        ef  = mis ? 5'b01111 : (tk ? 5'b01000 : 5'b00000);
        ja  = tk ? tgt : (bus.id_ex_pc + 1) % (1 << AW);
        check("flush", bus.flush, ef);
        check("jump_address", bus.jump_address, ja);
        check("branch_count", bus.branch_count, exp_bc());
        check("mispredict_count", bus.mispredict_count, exp_mc());
        ei = bus.id_ex_pc % N;
        et = bus.id_ex_pc / N;
        @(posedge clk);
        if (reset && res) begin
            if (m_valid[ei] && m_tag[ei] == et) begin
                if (tk) begin
                    m_ctr[ei] = (m_ctr[ei] == CMAX) ? CMAX : m_ctr[ei] + 1;
                    m_tgt[ei] = tgt;
                end else begin
                    m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
                end
            end else if (tk) begin
                m_valid[ei] = 1; m_tag[ei] = et; m_tgt[ei] = tgt; m_ctr[ei] = CWEAK;
                m_unc[ei] = (bus.jop == JMP_OP_J || bus.jop == JMP_OP_JR);
            end
            m_bc++;
            if (mis) m_mc++;
        end
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 16'h0010;
            1: return 16'h0013;
            2: return 16'h0023;
            3: return 16'h0033;
            4: return 16'h0025;
            5: return 16'hFFFF;
            6: return 16'h001F;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic random_steps(input int n);
        for (int i = 0; i < n; i++) begin
            logic [15:0] p, ip, ra, ia, bta;
            bit bt;
            p  = pick_addr();
            ip = pick_addr();
            ra = ($urandom_range(0, 1) == 0) ? 16'h0200 : pick_addr();
            ia = ($urandom_range(0, 1) == 0) ? 16'h0040 : pick_addr();
            if ($urandom_range(0, 3) != 0) begin
                bt  = m_pred_tk(ip);
                bta = 16'(m_pred_tgt(ip));
            end else begin
                bt  = 1'($urandom);
                bta = pick_addr();
            end
            drive(p, ($urandom_range(0, 7) != 0), 4'($urandom_range(0, 10)),
                  1'($urandom), 1'($urandom), 1'($urandom), ip, ra, ia, bt, bta);
            step();
        end
    endtask

    task automatic reset_checks(input string tag);
        #1;
        check({tag, "_take_branch"}, bus.take_branch, 0);
        check({tag, "_branch_count"}, bus.branch_count, 0);
        check({tag, "_mispredict_count"}, bus.mispredict_count, 0);
    endtask

    initial begin
        model_clear();
        idle(16'h0010);
        #3 reset = 1'b0;
        reset_checks("por");
        check("por_branch_predict", bus.branch_predict, 0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        random_steps(150);

        // Make sure 0x0010 is populated, then reset in mid-run.
        drive(16'h0010, 1, JMP_OP_J, 0, 0, 0, 16'h0010, 0, 16'h0040, 0, 0);
        step();
        idle(16'h0010);
        #1 check("pre_reset_take_branch", bus.take_branch, 1);
        // A resolving op while reset is low must not touch the BTB.
        drive(16'h0010, 1, JMP_OP_J, 0, 0, 0, 16'h0010, 0, 16'h0040, 0, 0);
        reset = 1'b0;
        model_clear();
        reset_checks("midrst");
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        idle(16'h0010);
        reset_checks("postrst");

        // First JNE: cold miss, taken -> full flush, allocate.
        drive(16'h0010, 1, JMP_OP_JNE, 0, 0, 0, 16'h0010, 0, 16'h0040, 0, 0);
        #1 check("jne1_flush", bus.flush, 5'b01111);
        check("jne1_jump", bus.jump_address, 16'h0040);
        step();
        idle(16'h0010);
        #1 check("jne1_lookup_tb", bus.take_branch, 1);
        check("jne1_lookup_bp", bus.branch_predict, 16'h0040);
        check("idle_jump", bus.jump_address, 16'h0101);
        step();
        // Not taken while predicted taken: mispredict, ctr 10 -> 01.
        drive(16'h0010, 1, JMP_OP_JNE, 1, 0, 0, 16'h0010, 0, 16'h0040, 1, 16'h0040);
        #1 check("jne2_flush", bus.flush, 5'b01111);
        check("jne2_jump", bus.jump_address, 16'h0011);
        step();
        // Not taken again: ctr 01 -> 00, correct prediction.
        drive(16'h0010, 1, JMP_OP_JNE, 1, 0, 0, 16'h0010, 0, 16'h0040, 0, 0);
        #1 check("jne3_flush", bus.flush, 0);
        step();
        drive(16'h0010, 1, JMP_OP_JNE, 1, 0, 0, 16'h0010, 0, 16'h0040, 0, 0);
        step();
        idle(16'h0010);
        #1 check("jne_sat_tb", bus.take_branch, 0);
        step();
        // One taken resolution from a saturated-low counter stays not-taken.
        drive(16'h0010, 1, JMP_OP_JNE, 0, 0, 0, 16'h0010, 0, 16'h0040, 0, 0);
        step();
        idle(16'h0010);
        #1 check("jne_sat_up_tb", bus.take_branch, 0);
        step();

        // JR with a stale target.
        drive(16'h0025, 1, JMP_OP_JR, 0, 0, 0, 16'h0025, 16'h0100, 0, 0, 0);
        step();
        drive(16'h0025, 1, JMP_OP_JR, 0, 0, 0, 16'h0025, 16'h0200, 0, 1, 16'h0100);
        #1 check("jr_flush", bus.flush, 5'b01111);
        check("jr_jump", bus.jump_address, 16'h0200);
        step();
        idle(16'h0025);
        #1 check("jr_bp", bus.branch_predict, 16'h0200);
        step();
        drive(16'h0025, 1, JMP_OP_JR, 0, 0, 0, 16'h0025, 16'h0200, 0, 1, 16'h0200);
        #1 check("jr_rep_flush", bus.flush, 5'b01000);
        step();

        // JLE / JGE include equality.
        drive(16'h0030, 1, JMP_OP_JLE, 1, 0, 0, 16'h0030, 0, 16'h0050, 0, 0);
        #1 check("jle_jump", bus.jump_address, 16'h0050);
        step();
        drive(16'h0031, 1, JMP_OP_JGE, 0, 0, 0, 16'h0031, 0, 16'h0060, 0, 0);
        #1 check("jge_flush", bus.flush, 0);
        check("jge_jump", bus.jump_address, 16'h0032);
        step();

        // Aliasing at index 3, and same-index read during the evicting write.
        drive(16'h0013, 1, JMP_OP_JEQ, 1, 0, 0, 16'h0013, 0, 16'h0060, 0, 0);
        step();
        drive(16'h0013, 1, JMP_OP_J, 0, 0, 0, 16'h0023, 0, 16'h0070, 0, 0);
        #1 check("rw_old_tb", bus.take_branch, 1);
        check("rw_old_bp", bus.branch_predict, 16'h0060);
        step();
        idle(16'h0013);
        #1 check("alias_tb", bus.take_branch, 0);
        check("alias_bp", bus.branch_predict, 0);
        step();
        idle(16'h0023);
        #1 check("alias_new_bp", bus.branch_predict, 16'h0070);
        step();

        // PC+1 wraps at the top of the address space.
        drive(16'hFFFF, 1, JMP_OP_JNE, 1, 0, 0, 16'hFFFF, 0, 16'h0040, 0, 0);
        #1 check("wrap_jump", bus.jump_address, 16'h0000);
        step();

        random_steps(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
